// File: rtl/spi_rx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_rx_framer : polls the SPI slave register port and deframes              |
// |   SYNC, LEN, payload[LEN], XOR-checksum frames onto a valid/ready stream.   |
// | Optional macro SPI_RX_TIMEOUT_EN enables the inter-byte timeout.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module spi_rx_framer #(
   parameter logic [7:0]  SYNC_BYTE      = 8'h7E,
   parameter int unsigned MAX_LEN        = 64,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        spi_select,
   output logic        read_n,
   output logic        write_n,
   output logic [2:0]  mem_addr,
   output logic [15:0] data_from_cpu,
   input  logic [15:0] data_to_cpu,
   input  logic        dataavailable,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_sof,
   output logic        m_eof,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [7:0]  cur_len
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [1:0] {B_IDLE, B_RD1, B_RD2, B_GAP}    bus_state_t;
   typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAY, P_CSUM}   parse_state_t;

   bus_state_t   bus_q, bus_d;
   parse_state_t parse_q, parse_d;

   logic [7:0] rx_byte_q,   rx_byte_d;
   logic [7:0] csum_q,      csum_d;
   logic [7:0] remaining_q, remaining_d;
   logic [7:0] cur_len_q,   cur_len_d;
   logic [7:0] m_data_q,    m_data_d;
   logic       m_valid_q,   m_valid_d;
   logic       m_sof_q,     m_sof_d;
   logic       m_eof_q,     m_eof_d;
   logic       frame_ok_q,  frame_ok_d;
   logic       frame_err_q, frame_err_d;

   logic       w_gap;
   logic       w_timeout_hit;
   logic       unused_hi;

   assign unused_hi = ^data_to_cpu[15:8];

   // Bus master: a new read starts only once the previous payload byte has left.
   always_comb begin
      bus_d = bus_q;
      case (bus_q)
         B_IDLE:  if (dataavailable && !m_valid_q) bus_d = B_RD1;
         B_RD1:   bus_d = B_RD2;
         B_RD2:   bus_d = B_GAP;
         B_GAP:   bus_d = B_IDLE;
         default: bus_d = B_IDLE;
      endcase
   end

   assign w_gap     = (bus_q == B_GAP);
   assign rx_byte_d = (bus_q == B_RD2) ? data_to_cpu[7:0] : rx_byte_q;

`ifdef SPI_RX_TIMEOUT_EN
   localparam int unsigned     TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TO_PRE = TW'(TIMEOUT_CYCLES - 2);

   logic [TW-1:0] to_cnt_q, to_cnt_d;

   // Hit is flagged one count early so frame_err lands as the count reaches TIMEOUT_CYCLES-1.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (w_gap || parse_q == P_HUNT) to_cnt_d = '0;
      else                            to_cnt_d = to_cnt_q + 1'b1;
   end

   assign w_timeout_hit = !w_gap && (parse_q != P_HUNT) && (to_cnt_q == TO_PRE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) to_cnt_q <= '0;
      else          to_cnt_q <= to_cnt_d;
   end
`else
   assign w_timeout_hit = 1'b0;
`endif

   always_comb begin
      parse_d     = parse_q;
      csum_d      = csum_q;
      remaining_d = remaining_q;
      cur_len_d   = cur_len_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_sof_d     = m_sof_q;
      m_eof_d     = m_eof_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
         m_sof_d   = 1'b0;
         m_eof_d   = 1'b0;
      end

      if (w_gap) begin
         case (parse_q)
            P_HUNT: if (rx_byte_q == SYNC_BYTE) parse_d = P_LEN;
            P_LEN: begin
               if (rx_byte_q == 8'd0 || rx_byte_q > MAX_LEN_B) begin
                  frame_err_d = 1'b1;
                  parse_d     = P_HUNT;
               end else begin
                  cur_len_d   = rx_byte_q;
                  csum_d      = rx_byte_q;
                  remaining_d = rx_byte_q;
                  parse_d     = P_PAY;
               end
            end
            P_PAY: begin
               m_data_d    = rx_byte_q;
               m_valid_d   = 1'b1;
               m_sof_d     = (remaining_q == cur_len_q);
               m_eof_d     = (remaining_q == 8'd1);
               csum_d      = csum_q ^ rx_byte_q;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) parse_d = P_CSUM;
            end
            P_CSUM: begin
               if (rx_byte_q == csum_q) frame_ok_d  = 1'b1;
               else                     frame_err_d = 1'b1;
               parse_d = P_HUNT;
            end
            default: parse_d = P_HUNT;
         endcase
      end else if (w_timeout_hit) begin
         // Abandoned frame: any byte still waiting is delivered but must not close a frame.
         frame_err_d = 1'b1;
         parse_d     = P_HUNT;
         m_eof_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_q       <= B_IDLE;
         parse_q     <= P_HUNT;
         rx_byte_q   <= 8'd0;
         csum_q      <= 8'd0;
         remaining_q <= 8'd0;
         cur_len_q   <= 8'd0;
         m_data_q    <= 8'd0;
         m_valid_q   <= 1'b0;
         m_sof_q     <= 1'b0;
         m_eof_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         bus_q       <= bus_d;
         parse_q     <= parse_d;
         rx_byte_q   <= rx_byte_d;
         csum_q      <= csum_d;
         remaining_q <= remaining_d;
         cur_len_q   <= cur_len_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_sof_q     <= m_sof_d;
         m_eof_q     <= m_eof_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign spi_select    = (bus_q == B_RD1) || (bus_q == B_RD2);
   assign read_n        = !spi_select;
   assign write_n       = 1'b1;
   assign mem_addr      = 3'd0;
   assign data_from_cpu = 16'h0000;
   assign m_data        = m_data_q;
   assign m_valid       = m_valid_q;
   assign m_sof         = m_sof_q;
   assign m_eof         = m_eof_q;
   assign frame_ok      = frame_ok_q;
   assign frame_err     = frame_err_q;
   assign cur_len       = cur_len_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_framer.sv
`default_nettype none
// tb_spi_rx_framer : directed and randomized frames against a slice-based frame model.
module tb_spi_rx_framer;

   localparam logic [7:0] SYNC    = 8'h7E;
   localparam int         MAX_LEN = 64;
   localparam int         TO      = 100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        spi_select, read_n, write_n;
   logic [2:0]  mem_addr;
   logic [15:0] data_from_cpu;
   logic [15:0] data_to_cpu;
   logic        dataavailable;
   logic [7:0]  m_data;
   logic        m_valid, m_ready, m_sof, m_eof;
   logic        frame_ok, frame_err;
   logic [7:0]  cur_len;

   spi_rx_framer #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .read_n(read_n),
      .write_n(write_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
      .data_to_cpu(data_to_cpu), .dataavailable(dataavailable),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
      .m_eof(m_eof), .frame_ok(frame_ok), .frame_err(frame_err), .cur_len(cur_len));

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0, cyc = 0;
   logic [7:0] slave_q[$];
   logic [7:0] sent_q[$];
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];
   int ok_cnt = 0, err_cnt = 0, exp_ok, exp_err, exp_len;
   int last_gap_cyc = 0, last_err_cyc = 0;
   logic prev_rd = 1'b0, prev_stall = 1'b0;
   logic [9:0] prev_beat = '0;

   always @(posedge clk) cyc++;

   // Slave register port model, stream sink and protocol watch, all at the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_rd    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_cmp++;
            if (!m_valid || {m_sof, m_eof, m_data} !== prev_beat) begin
               n_fail++;
               $display("FAIL stream_hold: got v=%0b beat=%h, required v=1 beat=%h", m_valid, {m_sof, m_eof, m_data}, prev_beat);
            end
         end
         if (frame_ok || frame_err) begin
            n_cmp++;
            if (frame_ok && frame_err) begin
               n_fail++;
               $display("FAIL pulse_excl: got ok=1 err=1, required at most one");
            end
         end
         if (m_valid && m_ready) got_q.push_back({m_sof, m_eof, m_data});
         if (frame_ok) ok_cnt++;
         if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
         if (read_n && prev_rd) begin
            if (slave_q.size() != 0) void'(slave_q.pop_front());
            last_gap_cyc = cyc;
         end
         prev_rd    = !read_n;
         prev_stall = m_valid && !m_ready;
         prev_beat  = {m_sof, m_eof, m_data};
      end
      dataavailable = (slave_q.size() != 0);
      data_to_cpu   = {8'h00, (slave_q.size() != 0) ? slave_q[0] : 8'h00};
   end

   task automatic tick();
      @(posedge clk); #3;
   endtask

   task automatic send(input logic [7:0] b);
      slave_q.push_back(b);
      sent_q.push_back(b);
   endtask

   task automatic clear_scoreboard();
      slave_q.delete(); sent_q.delete(); got_q.delete();
      ok_cnt = 0; err_cnt = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; m_ready = 1'b1;
      clear_scoreboard();
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((slave_q.size() != 0 || m_valid || spi_select) && n < 5000) begin tick(); n++; end
      n_cmp++;
      if (n >= 5000) begin n_fail++; $display("FAIL %s_drain: busy after %0d cycles, required idle", name, n); end
      repeat (4) tick();
   endtask

   // Reference: scan the byte stream by index, slicing out frames.
   task automatic run_model();
      int i, n, len;
      logic [7:0] cs;
      logic [9:0] e;
      exp_q.delete(); exp_ok = 0; exp_err = 0; exp_len = 0;
      n = sent_q.size(); i = 0;
      while (i < n) begin
         if (sent_q[i] != SYNC) begin i++; continue; end
         if (i + 1 >= n) break;
         len = int'(sent_q[i+1]);
         if (len == 0 || len > MAX_LEN) begin exp_err++; i += 2; continue; end
         exp_len = len;
         cs = 8'(len);
         for (int k = 0; k < len && i + 2 + k < n; k++) begin
            e = {(k == 0), (k == len - 1), sent_q[i+2+k]};
            exp_q.push_back(e);
            cs ^= sent_q[i+2+k];
         end
         if (i + 2 + len < n) begin
            if (sent_q[i+2+len] == cs) exp_ok++; else exp_err++;
         end
         i += len + 3;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; m_ready = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({spi_select, read_n, write_n, mem_addr, data_from_cpu} !== {1'b0, 1'b1, 1'b1, 3'd0, 16'h0}) begin
         n_fail++; $display("FAIL reset_bus: got %h, required %h", {spi_select, read_n, write_n, mem_addr, data_from_cpu}, {1'b0, 1'b1, 1'b1, 3'd0, 16'h0});
      end
      n_cmp++;
      if ({m_valid, m_sof, m_eof, m_data} !== 11'd0) begin
         n_fail++; $display("FAIL reset_stream: got %h, required 0", {m_valid, m_sof, m_eof, m_data});
      end
      n_cmp++;
      if ({frame_ok, frame_err, cur_len} !== 10'd0) begin
         n_fail++; $display("FAIL reset_status: got %h, required 0", {frame_ok, frame_err, cur_len});
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_good_frame();
      logic [9:0] want [3];
      want = '{10'h211, 10'h022, 10'h133};
      do_reset();
      foreach (want[i]) ;
      send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      wait_drain("good");
      n_cmp++;
      if (got_q.size() != 3) begin n_fail++; $display("FAIL good_count: got %0d bytes, required 3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL good_byte%0d: got %h, required %h", i, got_q[i], want[i]); end
      end
      n_cmp++;
      if (ok_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL good_status: got ok=%0d err=%0d, required ok=1 err=0", ok_cnt, err_cnt); end
      n_cmp++;
      if (cur_len !== 8'd3) begin n_fail++; $display("FAIL good_len: got %0d, required 3", cur_len); end
   endtask

   task automatic test_bad_csum();
      do_reset();
      send(8'h7E); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
      wait_drain("badcs");
      n_cmp++;
      if (got_q.size() != 2 || got_q[0] !== 10'h2AA || got_q[1] !== 10'h155) begin
         n_fail++; $display("FAIL badcs_payload: got %0d bytes first=%h, required 2 bytes 2aa,155", got_q.size(), (got_q.size() != 0) ? got_q[0] : 10'h0);
      end
      n_cmp++;
      if (ok_cnt != 0 || err_cnt != 1) begin n_fail++; $display("FAIL badcs_status: got ok=%0d err=%0d, required ok=0 err=1", ok_cnt, err_cnt); end
   endtask

   task automatic test_bad_len();
      do_reset();
      send(8'h7E); send(8'h00); send(8'h7E); send(8'h41);
      wait_drain("badlen");
      n_cmp++;
      if (err_cnt != 2 || ok_cnt != 0) begin n_fail++; $display("FAIL badlen_err: got ok=%0d err=%0d, required ok=0 err=2", ok_cnt, err_cnt); end
      n_cmp++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL badlen_payload: got %0d bytes, required 0", got_q.size()); end
      n_cmp++;
      if (cur_len !== 8'd0) begin n_fail++; $display("FAIL badlen_curlen: got %0d, required 0", cur_len); end
      send(8'h7E); send(8'h01); send(8'h33); send(8'h32);
      wait_drain("badlen2");
      n_cmp++;
      if (ok_cnt != 1 || err_cnt != 2 || cur_len !== 8'd1) begin
         n_fail++; $display("FAIL badlen_rehunt: got ok=%0d err=%0d len=%0d, required ok=1 err=2 len=1", ok_cnt, err_cnt, cur_len);
      end
   endtask

   task automatic test_resync_backpressure();
      int n = 0;
      do_reset();
      m_ready = 1'b0;
      send(8'h00); send(8'hFF); send(8'h7E); send(8'h01); send(8'h5A); send(8'h5B);
      while (!m_valid && n < 500) begin tick(); n++; end
      n_cmp++;
      if ({m_valid, m_sof, m_eof, m_data} !== {3'b111, 8'h5A}) begin
         n_fail++; $display("FAIL bp_beat: got %h, required %h", {m_valid, m_sof, m_eof, m_data}, {3'b111, 8'h5A});
      end
      repeat (20) tick();
      n_cmp++;
      if (slave_q.size() != 1 || !m_valid) begin
         n_fail++; $display("FAIL bp_stall: got unread=%0d valid=%0b, required unread=1 valid=1", slave_q.size(), m_valid);
      end
      m_ready = 1'b1;
      wait_drain("bp");
      n_cmp++;
      if (ok_cnt != 1 || err_cnt != 0 || got_q.size() != 1) begin
         n_fail++; $display("FAIL bp_status: got ok=%0d err=%0d bytes=%0d, required 1 0 1", ok_cnt, err_cnt, got_q.size());
      end
   endtask

`ifdef SPI_RX_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      do_reset();
      send(8'h7E); send(8'h04); send(8'h01);
      wait_drain("to");
      while (err_cnt == 0 && n < 400) begin tick(); n++; end
      n_cmp++;
      if (err_cnt != 1 || last_err_cyc - last_gap_cyc != TO) begin
         n_fail++; $display("FAIL to_delay: got err=%0d delay=%0d, required err=1 delay=%0d", err_cnt, last_err_cyc - last_gap_cyc, TO);
      end
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== 10'h201) begin
         n_fail++; $display("FAIL to_payload: got %0d bytes, required 1 byte 201");
      end
      send(8'h7E); send(8'h01); send(8'h10); send(8'h11);
      wait_drain("to2");
      n_cmp++;
      if (ok_cnt != 1 || err_cnt != 1) begin n_fail++; $display("FAIL to_recover: got ok=%0d err=%0d, required ok=1 err=1", ok_cnt, err_cnt); end
   endtask
`else
   task automatic test_timeout();
      do_reset();
      send(8'h7E); send(8'h04); send(8'h01);
      wait_drain("nto");
      repeat (300) tick();
      n_cmp++;
      if (err_cnt != 0 || ok_cnt != 0) begin n_fail++; $display("FAIL nto_idle: got ok=%0d err=%0d, required 0 0", ok_cnt, err_cnt); end
      send(8'h02); send(8'h03); send(8'h04); send(8'h00);
      wait_drain("nto2");
      n_cmp++;
      if (ok_cnt != 1 || got_q.size() != 4 || got_q[3] !== 10'h104) begin
         n_fail++; $display("FAIL nto_finish: got ok=%0d bytes=%0d, required ok=1 bytes=4 last=104", ok_cnt, got_q.size());
      end
   endtask
`endif

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      send(8'h7E); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      while (got_q.size() < 2 && n < 500) begin tick(); n++; end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({spi_select, read_n, m_valid, m_sof, m_eof, m_data, frame_ok, frame_err, cur_len} !== {2'b01, 11'd0, 10'd0}) begin
         n_fail++; $display("FAIL rstmid_outputs: got %h, required %h",
            {spi_select, read_n, m_valid, m_sof, m_eof, m_data, frame_ok, frame_err, cur_len}, {2'b01, 11'd0, 10'd0});
      end
      tick();
      clear_scoreboard();
      tick();
      reset_n = 1'b1;
      tick();
      send(8'h7E); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFD);
      wait_drain("rstmid");
      n_cmp++;
      if (ok_cnt != 1 || err_cnt != 0 || got_q.size() != 2 || cur_len !== 8'd2) begin
         n_fail++; $display("FAIL rstmid_frame: got ok=%0d err=%0d bytes=%0d len=%0d, required 1 0 2 2", ok_cnt, err_cnt, got_q.size(), cur_len);
      end
   endtask

   task automatic test_random();
      int len, kind, n;
      logic [7:0] b, cs;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         for (int f = 0; f < 8; f++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
               for (int j = 0; j < $urandom_range(1, 3); j++) begin
                  do b = 8'($urandom_range(0, 255)); while (b == SYNC);
                  send(b);
               end
            end else if (kind == 3) begin
               send(SYNC);
               send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
               len = ($urandom_range(0, 4) == 0) ? MAX_LEN : $urandom_range(1, 12);
               send(SYNC); send(8'(len));
               cs = 8'(len);
               for (int j = 0; j < len; j++) begin
                  b = 8'($urandom_range(0, 255));
                  send(b);
                  cs ^= b;
               end
               send((kind == 2) ? (cs ^ 8'($urandom_range(1, 255))) : cs);
            end
         end
         n = 0;
         while (slave_q.size() != 0 && n < 20000) begin
            tick();
            m_ready = ($urandom_range(0, 3) != 0);
            n++;
         end
         m_ready = 1'b1;
         wait_drain("rand");
         run_model();
         n_cmp++;
         if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d bytes, required %0d", it, got_q.size(), exp_q.size()); end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h, required %h", it, i, got_q[i], exp_q[i]); end
         end
         n_cmp++;
         if (ok_cnt != exp_ok || err_cnt != exp_err) begin
            n_fail++; $display("FAIL rand%0d_status: got ok=%0d err=%0d, required ok=%0d err=%0d", it, ok_cnt, err_cnt, exp_ok, exp_err);
         end
         n_cmp++;
         if (int'(cur_len) != exp_len) begin n_fail++; $display("FAIL rand%0d_len: got %0d, required %0d", it, cur_len, exp_len); end
      end
   endtask

   initial begin
      reset_n = 1'b0; m_ready = 1'b1;
      dataavailable = 1'b0; data_to_cpu = 16'h0;
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_bad_len();
      test_resync_backpressure();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
